// File: rtl/accum_seq.sv
// rtl/accum_seq.sv - windowed signed 16-bit accumulation sequencer around a shared carry-select adder

// 16-bit carry-select adder: four 4-bit blocks, upper blocks precompute both carry-in cases
module CSA_16BIT (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);

  logic [4:0] carry;

  assign carry[0] = 1'b0;

  for (genvar k = 0; k < 4; k++) begin : g_blk
    logic [4:0] sum_c0;
    logic [4:0] sum_c1;

    assign sum_c0 = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]};
    assign sum_c1 = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + 5'd1;

    assign sum[4*k +: 4] = carry[k] ? sum_c1[3:0] : sum_c0[3:0];
    assign carry[k+1]    = carry[k] ? sum_c1[4]   : sum_c0[4];
  end

  assign cout = carry[4];

endmodule

// Accepts NUM_TERMS signed products, accumulates one per cycle, then holds the sum until taken
module accum_seq #(
  parameter int NUM_TERMS = 9,
  parameter int CNT_W     = 8,
  parameter int SATURATE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        ovf,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  logic [1:0]       state;
  logic [15:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;

  logic [15:0] raw;
  logic        unused_cout;
  logic        step_ovf;
  logic [15:0] next_acc;
  logic        take;

  // The one accumulation adder of the PE; its carry-out has no meaning for signed sums
  CSA_16BIT u_csa (
    .a    (acc),
    .b    (in_data),
    .sum  (raw),
    .cout (unused_cout)
  );

  assign step_ovf = (acc[15] == in_data[15]) && (raw[15] != acc[15]);
  assign take     = (state == ST_ACCUM) && in_valid;

  // Clamp toward the sign of the running sum when saturating, otherwise keep the wrapped value
  always_comb begin
    next_acc = raw;
    if ((SATURATE != 0) && step_ovf) begin
      next_acc = acc[15] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Window sequencing: clear overrides everything, then per-state handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= 16'h0000;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= 16'h0000;
            cnt   <= '0;
            ovf_q <= 1'b0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (take) begin
            acc   <= next_acc;
            ovf_q <= ovf_q | step_ovf;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_ACCUM) || (state == ST_DONE);
  assign out_data  = acc;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_accum_seq.sv
// tb/tb_accum_seq.sv - self-checking bench for accum_seq (saturating and wrapping instances)
`timescale 1ns/1ps
module tb_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        s_in_ready, s_out_valid, s_ovf, s_busy;
  logic [15:0] s_out_data;
  logic        w_in_ready, w_out_valid, w_ovf, w_busy;
  logic [15:0] w_out_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] win[$];

  always #5 clk = ~clk;

  accum_seq #(.NUM_TERMS(9), .CNT_W(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready),
    .ovf(s_ovf), .busy(s_busy)
  );

  accum_seq #(.NUM_TERMS(9), .CNT_W(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_ready(out_ready),
    .ovf(w_ovf), .busy(w_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: running signed integer sum, clamped or wrapped whenever it leaves 16-bit range
  task automatic model(input bit sat, output logic [15:0] sum, output logic o);
    int a;
    a = 0;
    o = 1'b0;
    foreach (win[i]) begin
      a = a + int'($signed(win[i]));
      if (a > 32767) begin
        o = 1'b1;
        a = sat ? 32767 : a - 65536;
      end else if (a < -32768) begin
        o = 1'b1;
        a = sat ? -32768 : a + 65536;
      end
    end
    sum = a[15:0];
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("in_ready_after_start", {30'd0, s_in_ready, w_in_ready}, 32'h3);
  endtask

  task automatic feed(input bit stall);
    int  i;
    int  guard;
    bit  acc_now;
    i = 0;
    guard = 0;
    while (i < win.size() && guard < 2000) begin
      in_data  = win[i];
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      acc_now  = in_valid && s_in_ready;
      chk("in_ready_in_accum", {31'd0, s_in_ready}, 32'd1);
      chk("no_early_out_valid", {31'd0, s_out_valid}, 32'd0);
      tick;
      if (acc_now) i++;
      guard++;
    end
    in_valid = 1'b0;
    chk("feed_completed", i, win.size());
  endtask

  task automatic check_result(input string tag);
    logic [15:0] es, ew;
    logic        os, ow;
    model(1'b1, es, os);
    model(1'b0, ew, ow);
    chk({tag, "_valid"}, {30'd0, s_out_valid, w_out_valid}, 32'h3);
    chk({tag, "_sat_data"}, {16'd0, s_out_data}, {16'd0, es});
    chk({tag, "_wrap_data"}, {16'd0, w_out_data}, {16'd0, ew});
    chk({tag, "_sat_ovf"}, {31'd0, s_ovf}, {31'd0, os});
    chk({tag, "_wrap_ovf"}, {31'd0, w_ovf}, {31'd0, ow});
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("idle_after_consume", {30'd0, s_busy, w_busy}, 32'h0);
  endtask

  task automatic set_rand_win(input int n, input bit big);
    win.delete();
    for (int i = 0; i < n; i++) begin
      win.push_back(big ? 16'($urandom) : 16'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    logic [15:0] held_s, held_w;
    logic [15:0] es;
    logic        os;

    rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_data = 16'h0000; out_ready = 1'b0;
    tick; tick;
    chk("reset_outputs", {s_in_ready, s_out_valid, s_ovf, s_busy, s_out_data},
        {4'b0000, 16'h0000});
    chk("reset_outputs_wrap", {w_in_ready, w_out_valid, w_ovf, w_busy, w_out_data},
        {4'b0000, 16'h0000});
    rst = 1'b0;
    tick;

    // basic sum, latency start -> out_valid = 10 cycles
    win = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
            16'h0001, 16'h0001, 16'h0001, 16'h0001};
    pulse_start;
    feed(1'b0);
    check_result("basic");
    chk("basic_literal", {16'd0, s_out_data}, 32'h0009);
    consume;

    // mixed signs
    win = '{16'h0005, 16'hFFFD, 16'h0010, 16'hFFF0, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pulse_start;
    feed(1'b0);
    check_result("mixed");
    chk("mixed_literal", {16'd0, s_out_data}, 32'h0002);
    consume;

    // positive overflow, saturating vs wrapping
    win = '{16'h7000, 16'h7000, 16'hF000, 16'hF000, 16'hF000,
            16'hF000, 16'hF000, 16'hF000, 16'hF000};
    pulse_start;
    feed(1'b0);
    check_result("ovf_pos");
    chk("ovf_pos_literal", {s_out_data, w_out_data}, {16'h0FFF, 16'h7000});
    consume;
    chk("ovf_persists_idle", {30'd0, s_ovf, w_ovf}, 32'h3);

    // negative overflow
    win = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pulse_start;
    feed(1'b0);
    check_result("ovf_neg");
    chk("ovf_neg_literal", {16'd0, s_out_data}, 32'h8000);
    consume;

    // random windows with random input stalls
    for (int k = 0; k < 4; k++) begin
      set_rand_win(9, 1'b1);
      pulse_start;
      feed(1'b1);
      check_result("rand_stall");
      consume;
    end

    // output backpressure with ignored start pulses
    set_rand_win(9, 1'b1);
    pulse_start;
    feed(1'b1);
    check_result("bp");
    held_s = s_out_data;
    held_w = w_out_data;
    for (int c = 0; c < 20; c++) begin
      start = 1'($urandom_range(0, 1));
      tick;
      chk("bp_hold", {s_out_valid, w_out_valid, s_in_ready, w_in_ready, s_out_data, w_out_data},
          {4'b1100, held_s, held_w});
    end
    start = 1'b0;
    check_result("bp_after");
    consume;

    // asynchronous reset after the 4th term
    win = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    pulse_start;
    feed(1'b0);
    rst = 1'b1;
    #1;
    chk("rst_abort", {s_in_ready, s_out_valid, s_ovf, s_busy, s_out_data},
        {4'b0000, 16'h0000});
    chk("rst_abort_wrap", {w_in_ready, w_out_valid, w_ovf, w_busy, w_out_data},
        {4'b0000, 16'h0000});
    #1;
    rst = 1'b0;
    tick;
    set_rand_win(9, 1'b0);
    pulse_start;
    feed(1'b0);
    check_result("after_rst");
    consume;

    // clear mid-window with a product presented: not consumed
    win = '{16'h0100, 16'h0020, 16'h0003};
    pulse_start;
    feed(1'b0);
    in_data  = 16'h1234;
    in_valid = 1'b1;
    clear    = 1'b1;
    tick;
    clear    = 1'b0;
    in_valid = 1'b0;
    model(1'b1, es, os);
    chk("clear_idle", {s_busy, s_ovf, s_out_valid, s_in_ready}, 4'b0000);
    chk("clear_acc_kept", {16'd0, s_out_data}, {16'd0, es});
    chk("clear_acc_literal", {16'd0, w_out_data}, 32'h0123);
    tick;
    chk("clear_stays_idle", {30'd0, s_busy, w_busy}, 32'h0);

    // back-to-back windows, start right after each consume
    for (int k = 0; k < 3; k++) begin
      set_rand_win(9, 1'b1);
      pulse_start;
      feed(k == 1);
      check_result("b2b");
      consume;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accum_seq.md
# accum_seq

Sequencing controller for the 16-bit CNN accumulation adder. It accepts a window of NUM_TERMS signed 16-bit partial products over a valid/ready stream and accumulates them one per cycle through a single shared `CSA_16BIT` instance. It then presents the window sum on a valid/ready output. It sits between the multiplier array and the activation/pooling stage, and it owns the only accumulation adder in the PE.

## Interface
- NUM_TERMS, 9: products per window (3x3 kernel); legal range 1..255.
- CNT_W, 8: term-counter width; must satisfy 2^CNT_W > NUM_TERMS.
- SATURATE, 1: 1 = clamp each step on signed overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a window; honoured only in IDLE.
- clear  in  1  synchronous abort; returns to IDLE from any state; takes priority over start and all handshakes.
- in_valid  in  1  product available.
- in_data  in  16  signed product.
- in_ready  out  1  high only in ACCUM.
- out_valid  out  1  high only in DONE.
- out_data  out  16  window sum; driven from the accumulator register.
- out_ready  in  1  downstream accepts the result.
- ovf  out  1  sticky: set if any step of the current window overflowed.
- busy  out  1  high in ACCUM or DONE.

## Operation
- State machine: IDLE, ACCUM, DONE.
- IDLE:
  - On start: clear acc, cnt and ovf to 0, then go to ACCUM.
  - Otherwise hold; acc and ovf keep the last window's values.
- ACCUM: each cycle with in_valid && in_ready:
  - Adder operands are acc and in_data; raw = CSA_16BIT sum (carry-out discarded).
  - Overflow: acc[15] == in_data[15] && raw[15] != acc[15].
  - SATURATE=1 with overflow: acc <= 0x7FFF if acc[15]==0, else 0x8000. Otherwise acc <= raw.
  - ovf <= ovf | overflow; cnt <= cnt+1.
  - When the accepted term is term NUM_TERMS (cnt == NUM_TERMS-1), go to DONE.
  - Cycles without in_valid leave all state unchanged. No timeout.
- DONE:
  - out_valid=1 and out_data=acc, both held stable until out_ready.
  - On out_valid && out_ready: go to IDLE.
- start is ignored outside IDLE.
- clear: next state IDLE. ovf is cleared and acc is left unchanged. A product presented in the same cycle as clear is not consumed.
- No extension bits: each accumulation step is exactly 16-bit signed arithmetic.

## Timing
- Reset values: state=IDLE, acc=0x0000, cnt=0, ovf=0, in_ready=0, out_valid=0, out_data=0x0000, busy=0.
- All outputs are registered or decoded from state. There is no combinational path from in_valid or out_ready to any output.
- start in cycle T gives in_ready=1 from T+1.
- Throughput: one term per cycle.
- The last term accepted in cycle T gives out_valid=1 in T+1.
- Minimum window time: start to out_valid is NUM_TERMS+1 cycles.
- Result consumed in cycle T gives IDLE in T+1. start is then accepted in T+1 at the earliest, so there is one dead cycle between windows.
- Asserting rst mid-window abandons the window immediately. All outputs return to reset values asynchronously, and no partial result is emitted.
- ovf is valid alongside out_valid and persists in IDLE until the next start or clear.
- NUM_TERMS=1: a single accepted term moves directly to DONE.

## Test plan
- Basic sum: NUM_TERMS=9, start, nine products of 0x0001 with in_valid held high -> out_valid exactly 10 cycles after start, out_data=0x0009, ovf=0.
- Mixed signs: products 0x0005, 0xFFFD, 0x0010, 0xFFF0, then five of 0x0000 -> out_data=0x0002, ovf=0.
- Overflow:
  - SATURATE=1, products 0x7000, 0x7000, then seven of 0xF000 -> per-step clamp gives 0x7FFF, then 0x7FFF - 7*0x1000 = 0x0FFF; out_data=0x0FFF, ovf=1.
  - SATURATE=0, same stream -> out_data = 0xE000 - 0x7000 = 0x7000, ovf=1.
  - Negative case, SATURATE=1, 0x8000 + 0xFFFF -> 0x8000.
- Stalls and backpressure:
  - in_valid toggled randomly -> sum unchanged and cnt advances only on accepted terms.
  - out_ready held low 20 cycles -> out_valid and out_data stable; in_ready=0 throughout; start pulses during DONE ignored.
- Abort: rst asserted after the 4th term -> all outputs at reset values immediately. A fresh window afterwards -> correct sum. clear in ACCUM with in_valid high -> IDLE next cycle, that product not consumed.
- Back-to-back windows: start pulsed in the cycle after each result is consumed, 3 windows -> three correct sums, one idle cycle between windows.
